// File: rtl/div_mod_unit.sv
// div_mod_unit: multi-cycle unsigned radix-2 restoring divider for the
// execute-stage modulo instruction. It produces one quotient bit per cycle,
// reports busy back to the control unit, and hands the result and destination
// register to the EWB writeback register with a one-cycle done pulse.
module div_mod_unit #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  div_ena,
  input  logic                  flush,
  input  logic                  sel_mod,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  div_state,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  div_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                  state_r;
  logic [WIDTH-1:0]        quo_r;
  logic [WIDTH-1:0]        rem_r;
  logic [WIDTH-1:0]        div_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    sel_r;
  logic [REG_ADDR_W-1:0]   rd_r;

  logic                    div_state_r;
  logic                    done_r;
  logic [WIDTH-1:0]        result_r;
  logic [REG_ADDR_W-1:0]   rd_out_r;
  logic                    div_zero_r;

  logic [WIDTH:0]          trial_s;
  logic                    borrow_s;
  logic [WIDTH-1:0]        quo_nxt_s;
  logic [WIDTH-1:0]        rem_nxt_s;
  logic                    start_s;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor. The partial remainder's MSB is always
  // zero before a shift (it holds at most k bits after k steps), so dropping
  // it keeps the trial exact in WIDTH+1 bits.
  always_comb begin
    trial_s  = {1'b0, rem_r[WIDTH-2:0], quo_r[WIDTH-1]} - {1'b0, div_r};
    borrow_s = trial_s[WIDTH];
    if (!borrow_s) begin
      rem_nxt_s = trial_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // A new operation may be accepted from IDLE or straight out of DONE
  // (back-to-back modulo); flush always rejects the start.
  always_comb begin
    case (state_r)
      IDLE, DONE: start_s = div_ena & ~flush;
      default:    start_s = 1'b0;
    endcase
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      quo_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      div_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      sel_r       <= 1'b0;
      rd_r        <= {REG_ADDR_W{1'b0}};
      div_state_r <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      rd_out_r    <= {REG_ADDR_W{1'b0}};
      div_zero_r  <= 1'b0;
    end else if (flush) begin
      // Abort: back to IDLE with result/rd_out/div_zero left untouched.
      state_r     <= IDLE;
      div_state_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start_s) begin
            div_r <= op_b;
            sel_r <= sel_mod;
            rd_r  <= rd_in;
            cnt_r <= CNT_W'(WIDTH - 1);
            if (op_b == {WIDTH{1'b0}}) begin
              // Divide by zero finishes at once: quotient all ones,
              // remainder equals the dividend.
              quo_r       <= {WIDTH{1'b1}};
              rem_r       <= op_a;
              state_r     <= DONE;
              div_state_r <= 1'b0;
              done_r      <= 1'b1;
              div_zero_r  <= 1'b1;
              result_r    <= sel_mod ? op_a : {WIDTH{1'b1}};
              rd_out_r    <= rd_in;
            end else begin
              quo_r       <= op_a;
              rem_r       <= {WIDTH{1'b0}};
              state_r     <= CALC;
              div_state_r <= 1'b1;
            end
          end else begin
            state_r     <= IDLE;
            div_state_r <= 1'b0;
          end
        end
        CALC: begin
          quo_r <= quo_nxt_s;
          rem_r <= rem_nxt_s;
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r     <= DONE;
            div_state_r <= 1'b0;
            done_r      <= 1'b1;
            div_zero_r  <= 1'b0;
            result_r    <= sel_r ? rem_nxt_s : quo_nxt_s;
            rd_out_r    <= rd_r;
          end else begin
            cnt_r       <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            div_state_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          div_state_r <= 1'b0;
        end
      endcase
    end
  end

  assign div_state = div_state_r;
  assign done      = done_r;
  assign result    = result_r;
  assign rd_out    = rd_out_r;
  assign div_zero  = div_zero_r;

endmodule
